// File: rtl/sumador_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  // Bit counter width; never narrower than one bit so WIDTH=1 still has a counter.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sumador1bit.sv
// Combinational full adder cell built from gate primitives.
module sumador1bit (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);

  logic p;
  logic g;
  logic pc;

  xor u_x0 (p, a, b);
  xor u_x1 (s, p, ci);
  and u_a0 (g, a, b);
  and u_a1 (pc, p, ci);
  or  u_o0 (co, g, pc);

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial adder: one full-adder cell and a carry flop process A+B+c_in LSB first.
module sumador_serial
  import sumador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] suma,
  output logic             c_out
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  estado_t          state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] suma_q, suma_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_co;

  sumador1bit u_fa (
    .s  (fa_s),
    .co (fa_co),
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    suma_d  = suma_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          carry_d = c_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = WIDTH'({fa_s, res_q} >> 1);
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Output registers take the final shift so suma is stable across IDLE and RUN.
          suma_d  = WIDTH'({fa_s, res_q} >> 1);
          c_out_d = fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      suma_q  <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      suma_q  <= suma_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign suma  = suma_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_sumador_serial.sv
// Scoreboard bench for sumador_serial (WIDTH=8 and WIDTH=1 instances).
module tb_sumador_serial;

  typedef struct {
    logic [8:0] val;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, c_in;
  logic [7:0] a, b;
  logic       busy, done, c_out;
  logic [7:0] suma;

  logic       start1, ci1;
  logic [0:0] a1, b1;
  logic       busy1, done1, co1;
  logic [0:0] suma1;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;
  logic [8:0] last8, last1;
  bit   have8 = 0, have1 = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sumador_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .c_in(c_in),
    .busy(busy), .done(done), .suma(suma), .c_out(c_out)
  );

  sumador_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .suma(suma1), .c_out(co1)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      have8 = 0;
    end else if (done === 1'b1) begin
      n_cmp++;
      if (q8.size() == 0) begin
        n_bad++;
        $display("FAIL w8_unexpected_done: done=1 with no operation pending (cycle %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("w8_result", {23'd0, c_out, suma}, {23'd0, e8.val});
        chk("w8_done_cycle", cyc, e8.cyc);
        $display("w8 op: {c_out,suma}=%0h expected %0h at cycle %0d", {c_out, suma}, e8.val, cyc);
        last8 = e8.val;
        have8 = 1;
      end
    end else if (busy === 1'b0 && have8) begin
      chk("w8_hold", {23'd0, c_out, suma}, {23'd0, last8});
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      have1 = 0;
    end else if (done1 === 1'b1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL w1_unexpected_done: done=1 with no operation pending (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("w1_result", {30'd0, co1, suma1}, {23'd0, e1.val});
        chk("w1_done_cycle", cyc, e1.cyc);
        $display("w1 op: {c_out,suma}=%0h expected %0h at cycle %0d", {co1, suma1}, e1.val, cyc);
        last1 = e1.val;
        have1 = 1;
      end
    end else if (busy1 === 1'b0 && have1) begin
      chk("w1_hold", {30'd0, co1, suma1}, {23'd0, last1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [8:0] v, input int lat);
    exp_t e;
    e.val = v;
    e.cyc = cyc + 1 + lat;
    q8.push_back(e);
  endtask

  task automatic drain8();
    int i;
    for (i = 0; i < 80; i++) begin
      if (q8.size() == 0) break;
      @(negedge clk);
    end
    if (q8.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w8_timeout: %0d results still pending", q8.size());
      q8.delete();
    end
  endtask

  task automatic drain1();
    int i;
    for (i = 0; i < 40; i++) begin
      if (q1.size() == 0) break;
      @(negedge clk);
    end
    if (q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w1_timeout: %0d results still pending", q1.size());
      q1.delete();
    end
  endtask

  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc, input logic [8:0] req);
    tick();
    a = va; b = vb; c_in = vc; start = 1'b1;
    push8(req, 8);
    tick();
    start = 1'b0;
    drain8();
    repeat (2) tick();
  endtask

  task automatic run1(input logic va, input logic vb, input logic vc, input logic [8:0] req);
    exp_t e;
    tick();
    a1 = va; b1 = vb; ci1 = vc; start1 = 1'b1;
    e.val = req;
    e.cyc = cyc + 1 + 1;
    q1.push_back(e);
    tick();
    start1 = 1'b0;
    drain1();
    repeat (2) tick();
  endtask

  initial begin
    int bc;
    int j;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_suma", {24'd0, suma}, 32'd0);
    chk("reset_c_out", {31'd0, c_out}, 32'd0);
    chk("reset_w1_busy", {31'd0, busy1}, 32'd0);

    // Basic add with latency and busy-length check.
    tick();
    a = 8'h3C; b = 8'h05; c_in = 1'b0; start = 1'b1;
    push8(9'h041, 8);
    tick();
    start = 1'b0;
    bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
    end
    chk("busy_cycles", bc, 9);
    drain8();
    repeat (2) tick();

    run8(8'hFF, 8'h01, 1'b0, 9'h100);
    run8(8'h00, 8'h00, 1'b1, 9'h001);

    // Start pulsed again during RUN with new operands is ignored.
    tick();
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    push8(9'h030, 8);
    tick();
    start = 1'b0; a = 8'hAA; b = 8'h55; c_in = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain8();
    repeat (12) tick();

    // Reset in the 4th RUN cycle aborts the operation.
    tick();
    a = 8'h3C; b = 8'h05; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_suma", {24'd0, suma}, 32'd0);
    chk("abort_c_out", {31'd0, c_out}, 32'd0);
    repeat (15) tick();
    run8(8'h12, 8'h34, 1'b1, 9'h047);

    // Back-to-back with start held high: one result every 10 cycles.
    tick();
    a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
    for (j = 0; j < 3; j++) push8(9'h100, 8 + 10 * j);
    for (j = 0; j < 60; j++) begin
      tick();
      if (q8.size() == 0) break;
    end
    start = 1'b0;
    if (q8.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w8_b2b_timeout: %0d results still pending", q8.size());
      q8.delete();
    end
    repeat (15) tick();

    // WIDTH=1 instance.
    run1(1'b1, 1'b1, 1'b1, 9'h003);
    run1(1'b1, 1'b0, 1'b0, 9'h001);
    run1(1'b0, 1'b0, 1'b0, 9'h000);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
